// File: rtl/tank_pkg.sv
// Shared defaults and types for the water tank plant model and the level controller bench.
package tank_pkg;

  localparam int DEF_LEVEL_W    = 8;
  localparam int DEF_MAX_LEVEL  = 200;
  localparam int DEF_LOW_MARK   = 40;
  localparam int DEF_HIGH_MARK  = 160;
  localparam int DEF_INIT_LEVEL = 0;
  localparam int DEF_FILL_DIV   = 4;
  localparam int DEF_DRAIN_DIV  = 8;
  localparam int DEF_DEBOUNCE   = 3;

  typedef logic [DEF_LEVEL_W-1:0] level_t;

  // A divide-by-1 counter never leaves zero but still needs one bit of storage.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/level_debounce.sv
// Debounces one tank sensor line: the output follows raw only after DEBOUNCE
// consecutive mismatching cycles.
module level_debounce
  import tank_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic init_value,
  input  logic raw,
  output logic out
);

  localparam int DBW = cnt_width(DEBOUNCE);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  logic [DBW-1:0] dbc;

  // Any cycle where raw agrees with the output throws away the partial count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbc <= '0;
      out <= init_value;
    end else if (raw == out) begin
      dbc <= '0;
    end else if (dbc == DB_LAST) begin
      dbc <= '0;
      out <= raw;
    end else begin
      dbc <= dbc + 1'b1;
    end
  end

endmodule

// File: rtl/tank_level_sensor.sv
// Plant model of the water tank: integrates pump and consumer draw into a level
// and drives debounced low/high sensor lines plus a sticky overflow alarm.
module tank_level_sensor
  import tank_pkg::*;
#(
  parameter int LEVEL_W    = DEF_LEVEL_W,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int LOW_MARK   = DEF_LOW_MARK,
  parameter int HIGH_MARK  = DEF_HIGH_MARK,
  parameter int INIT_LEVEL = DEF_INIT_LEVEL,
  parameter int FILL_DIV   = DEF_FILL_DIV,
  parameter int DRAIN_DIV  = DEF_DRAIN_DIV,
  parameter int DEBOUNCE   = DEF_DEBOUNCE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               motor,
  input  logic               drain_en,
  output logic [LEVEL_W-1:0] level,
  output logic               low_level,
  output logic               high_level,
  output logic               overflow
);

  localparam int FCW = cnt_width(FILL_DIV);
  localparam int DCW = cnt_width(DRAIN_DIV);
  localparam logic [FCW-1:0] FILL_LAST  = FCW'(FILL_DIV - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_DIV - 1);

  localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LOW_L  = LEVEL_W'(LOW_MARK);
  localparam logic [LEVEL_W-1:0] HIGH_L = LEVEL_W'(HIGH_MARK);
  localparam logic [LEVEL_W-1:0] INIT_L = LEVEL_W'(INIT_LEVEL);

  localparam logic INIT_LOW  = (INIT_LEVEL <= LOW_MARK);
  localparam logic INIT_HIGH = (INIT_LEVEL >= HIGH_MARK);

  logic [FCW-1:0] fcnt;
  logic [DCW-1:0] dcnt;
  logic           fill_tick;
  logic           drain_tick;
  logic           raw_low;
  logic           raw_high;

  assign fill_tick  = motor    & (fcnt == FILL_LAST);
  assign drain_tick = drain_en & (dcnt == DRAIN_LAST);

  // A single idle cycle discards any partially counted level unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
    end else if (!motor || fill_tick) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt <= '0;
    end else if (!drain_en || drain_tick) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Coincident ticks cancel; the level saturates at both ends instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level    <= INIT_L;
      overflow <= 1'b0;
    end else if (fill_tick && !drain_tick) begin
      if (level < MAX_L) begin
        level <= level + 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (drain_tick && !fill_tick) begin
      if (level != '0) begin
        level <= level - 1'b1;
      end
    end
  end

  assign raw_low  = (level <= LOW_L);
  assign raw_high = (level >= HIGH_L);

  level_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_low_debounce (
    .clk       (clk),
    .reset     (reset),
    .init_value(INIT_LOW),
    .raw       (raw_low),
    .out       (low_level)
  );

  level_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_high_debounce (
    .clk       (clk),
    .reset     (reset),
    .init_value(INIT_HIGH),
    .raw       (raw_high),
    .out       (high_level)
  );

endmodule
